// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the mips_cpu_bus fetch/data arbiter.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        M_I = 1'b0,
        M_D = 1'b1
    } master_id_t;

    localparam int MIPS_BUS_ADDR_W = 32;
    localparam int MIPS_BUS_DATA_W = 32;

    // Read data handed back to the master when the watchdog aborts a transfer.
    localparam logic [31:0] ARB_ABORT_DATA = 32'h0;

endpackage

// File: rtl/mips_bus_watchdog.sv
// Stall watchdog for the bus arbiter: counts slave waitrequest cycles while a
// grant is held and flags expiry on the last permitted stall cycle.
module mips_bus_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic stall,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] wd_cnt_q;
    logic [CNT_W-1:0] wd_cnt_d;

    // Next count: clear while idle, count stalled grant cycles, hold at saturation.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (clear) begin
            wd_cnt_d = '0;
        end else if (enable && stall && (wd_cnt_q != CNT_SAT)) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign expire = enable && stall && (wd_cnt_q == CNT_LAST);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter sharing the mips_cpu_bus slave port between instruction
// fetch and load/store. Optional macro MIPS_ARB_ROUND_ROBIN_EN switches tie
// resolution from fixed data-over-fetch priority to round robin.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W  = MIPS_BUS_ADDR_W,
    parameter int DATA_W  = MIPS_BUS_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic [DATA_W-1:0]   i_readdata,
    output logic                i_waitrequest,

    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_waitrequest,

    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_waitrequest,

    output logic                grant_i,
    output logic                grant_d,
    output logic                bus_error
);

    arb_state_t state_q;
    logic       grant_i_q;
    logic       grant_d_q;
    logic       req_i;
    logic       req_d;
    logic       req_g;
    logic       pick_d;
    logic       complete;
    logic       abort;
    logic       xfer_end;
    logic       wd_expire;
    logic [DATA_W-1:0] grant_rdata;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    master_id_t last_grant_q;
`endif

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    // Data wins a tie unless round robin says fetch's turn has come.
`ifdef MIPS_ARB_ROUND_ROBIN_EN
    assign pick_d = req_d && (!req_i || (last_grant_q == M_I));
`else
    assign pick_d = req_d;
`endif

    assign req_g = (state_q == GRANT_I) ? req_i :
                   (state_q == GRANT_D) ? req_d : 1'b0;

    // Abort only applies while the granted master is still asking; a dropped
    // request just falls back to IDLE silently.
    assign complete  = req_g && !s_waitrequest;
    assign abort     = req_g && wd_expire;
    assign xfer_end  = complete || abort;
    assign bus_error = abort;

    assign grant_rdata = complete ? s_readdata :
                         abort    ? DATA_W'(ARB_ABORT_DATA) : '0;

    mips_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == IDLE),
        .enable (state_q != IDLE),
        .stall  (s_waitrequest),
        .expire (wd_expire)
    );

    // Arbitration FSM with registered grant flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_i_q    <= 1'b0;
            grant_d_q    <= 1'b0;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
            last_grant_q <= M_D;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q      <= GRANT_D;
                        grant_d_q    <= 1'b1;
                        grant_i_q    <= 1'b0;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
                        last_grant_q <= M_D;
`endif
                    end else if (req_i) begin
                        state_q      <= GRANT_I;
                        grant_i_q    <= 1'b1;
                        grant_d_q    <= 1'b0;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
                        last_grant_q <= M_I;
`endif
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (!req_g || xfer_end) begin
                        state_q   <= IDLE;
                        grant_i_q <= 1'b0;
                        grant_d_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    grant_i_q <= 1'b0;
                    grant_d_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant_i = grant_i_q;
    assign grant_d = grant_d_q;

    // Route the granted master onto the slave port and steer responses back.
    always_comb begin
        s_address     = '0;
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_writedata   = '0;
        s_byteenable  = '0;
        i_readdata    = '0;
        d_readdata    = '0;
        i_waitrequest = req_i;
        d_waitrequest = req_d;
        case (state_q)
            GRANT_I: begin
                s_address     = i_address;
                s_read        = i_read;
                s_byteenable  = '1;
                i_waitrequest = !xfer_end;
                i_readdata    = grant_rdata;
                d_waitrequest = 1'b1;
            end
            GRANT_D: begin
                s_address     = d_address;
                s_read        = d_read;
                s_write       = d_write;
                s_writedata   = d_writedata;
                s_byteenable  = d_byteenable;
                d_waitrequest = !xfer_end;
                d_readdata    = grant_rdata;
                i_waitrequest = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed self-checking bench for mips_bus_arbiter (TIMEOUT = 16).
module tb_mips_bus_arbiter;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] i_address = '0;
    logic        i_read = 1'b0;
    logic [31:0] i_readdata;
    logic        i_waitrequest;
    logic [31:0] d_address = '0;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_writedata = '0;
    logic [3:0]  d_byteenable = '0;
    logic [31:0] d_readdata;
    logic        d_waitrequest;
    logic [31:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic [31:0] s_readdata = '0;
    logic        s_waitrequest = 1'b0;
    logic        grant_i;
    logic        grant_d;
    logic        bus_error;

    int errors = 0;
    int checks = 0;

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read), .i_readdata(i_readdata),
        .i_waitrequest(i_waitrequest),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .grant_i(grant_i), .grant_d(grant_d), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_grant_i", grant_i, 0);
        chk("rst_grant_d", grant_d, 0);
        chk("rst_s_read", s_read, 0);
        chk("rst_s_addr", s_address, 0);
        chk("rst_i_wait", i_waitrequest, 0);
        chk("rst_bus_err", bus_error, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Simultaneous fetch and store: first tie after reset
        i_address = 32'hBFC00000; i_read = 1'b1;
        d_address = 32'hBFC00100; d_write = 1'b1;
        d_writedata = 32'h1; d_byteenable = 4'hF;
        s_waitrequest = 1'b0; s_readdata = 32'h24020005;
        #1;
        chk("tie_idle_i_wait", i_waitrequest, 1);
        chk("tie_idle_d_wait", d_waitrequest, 1);
        chk("tie_idle_s_write", s_write, 0);
        tick();
        chk("tie1_grant_i", grant_i, RR);
        chk("tie1_grant_d", grant_d, !RR);
        chk("tie1_s_addr", s_address, RR ? 32'hBFC00000 : 32'hBFC00100);
        chk("tie1_s_write", s_write, !RR);
        chk("tie1_s_wdata", s_writedata, RR ? 32'h0 : 32'h1);
        chk("tie1_s_be", s_byteenable, 4'hF);
        chk("tie1_i_wait", i_waitrequest, !RR);
        chk("tie1_d_wait", d_waitrequest, RR);
        chk("tie1_i_rdata", i_readdata, RR ? 32'h24020005 : 32'h0);
        i_read  = !RR;
        d_write = RR;
        tick();
        chk("tie_gap_grant_i", grant_i, 0);
        chk("tie_gap_grant_d", grant_d, 0);
        tick();
        chk("tie2_grant_i", grant_i, !RR);
        chk("tie2_grant_d", grant_d, RR);
        chk("tie2_s_addr", s_address, RR ? 32'hBFC00100 : 32'hBFC00000);
        i_read = 1'b0; d_write = 1'b0;
        tick();

        // Fetch only, zero-wait slave
        i_address = 32'hBFC00000; i_read = 1'b1;
        s_readdata = 32'h24020005;
        #1;
        chk("f_idle_grant_i", grant_i, 0);
        chk("f_idle_s_read", s_read, 0);
        tick();
        chk("f_grant_i", grant_i, 1);
        chk("f_s_addr", s_address, 32'hBFC00000);
        chk("f_s_read", s_read, 1);
        chk("f_s_write", s_write, 0);
        chk("f_s_be", s_byteenable, 4'hF);
        chk("f_i_wait", i_waitrequest, 0);
        chk("f_i_rdata", i_readdata, 32'h24020005);
        chk("f_d_rdata", d_readdata, 0);
        i_read = 1'b0;
        tick();
        chk("f_back_idle", grant_i, 0);

        // Data read with three slave wait cycles
        d_address = 32'h00000100; d_read = 1'b1; d_byteenable = 4'h3;
        s_waitrequest = 1'b1; s_readdata = 32'hCAFEF00D;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("w3_grant_d_%0d", k), grant_d, 1);
            chk($sformatf("w3_d_wait_%0d", k), d_waitrequest, 1);
            chk($sformatf("w3_bus_err_%0d", k), bus_error, 0);
        end
        chk("w3_s_be", s_byteenable, 4'h3);
        s_waitrequest = 1'b0;
        #1;
        chk("w3_done_d_wait", d_waitrequest, 0);
        chk("w3_done_rdata", d_readdata, 32'hCAFEF00D);
        chk("w3_done_bus_err", bus_error, 0);
        d_read = 1'b0;
        tick();
        chk("w3_back_idle", grant_d, 0);

        // Stuck slave: watchdog abort after 16 grant cycles, fetch pending
        d_read = 1'b1; s_waitrequest = 1'b1; s_readdata = 32'hDEADBEEF;
        tick();
        i_read = 1'b1; i_address = 32'hBFC00004;
        #1;
        chk("wd_grant_d", grant_d, 1);
        chk("wd_i_wait_blocked", i_waitrequest, 1);
        chk("wd_bus_err_1", bus_error, 0);
        chk("wd_d_wait_1", d_waitrequest, 1);
        for (int k = 2; k <= 16; k++) begin
            if (k > 2) tick();
            else begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("wd_bus_err_%0d", k), bus_error, (k == 16));
            chk($sformatf("wd_d_wait_%0d", k), d_waitrequest, (k != 16));
        end
        chk("wd_abort_rdata", d_readdata, 0);
        d_read = 1'b0; s_waitrequest = 1'b0; s_readdata = 32'h12345678;
        tick();
        chk("wd_idle_grant_d", grant_d, 0);
        chk("wd_idle_bus_err", bus_error, 0);
        chk("wd_idle_i_wait", i_waitrequest, 1);
        tick();
        chk("wd_then_grant_i", grant_i, 1);
        chk("wd_then_i_wait", i_waitrequest, 0);
        chk("wd_then_i_rdata", i_readdata, 32'h12345678);
        i_read = 1'b0;
        tick();

        // Reset mid GRANT_D
        d_address = 32'h00000200; d_write = 1'b1;
        d_writedata = 32'hA5A5A5A5; d_byteenable = 4'hF;
        s_waitrequest = 1'b1;
        tick();
        chk("rm_grant_d", grant_d, 1);
        chk("rm_s_write", s_write, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rm_grant_d_rst", grant_d, 0);
        chk("rm_s_write_rst", s_write, 0);
        chk("rm_s_addr_rst", s_address, 0);
        chk("rm_s_wdata_rst", s_writedata, 0);
        chk("rm_s_be_rst", s_byteenable, 0);
        chk("rm_d_wait_rst", d_waitrequest, 1);
        @(negedge clk);
        reset = 1'b0;
        s_waitrequest = 1'b0;
        tick();
        chk("rm_reissue_grant_d", grant_d, 1);
        chk("rm_reissue_s_wdata", s_writedata, 32'hA5A5A5A5);
        chk("rm_reissue_d_wait", d_waitrequest, 0);
        d_write = 1'b0;
        tick();
        chk("rm_back_idle", grant_d, 0);

        // Back-to-back fetches with data requesting continuously
        i_read = 1'b1; i_address = 32'hBFC00008;
        d_read = 1'b1; d_address = 32'h00000300;
        s_waitrequest = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk($sformatf("alt_grant_i_%0d", n), grant_i, RR && (n % 2 == 0));
            chk($sformatf("alt_grant_d_%0d", n), grant_d, !(RR && (n % 2 == 0)));
            chk($sformatf("alt_i_wait_%0d", n), i_waitrequest, !(RR && (n % 2 == 0)));
            chk($sformatf("alt_d_wait_%0d", n), d_waitrequest, RR && (n % 2 == 0));
            tick();
            chk($sformatf("alt_idle_%0d", n), grant_i | grant_d, 0);
        end
        i_read = 1'b0; d_read = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
